if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage pipeline, directly upstream of the decode stage. Generates fetch addresses, runs a request/acknowledge handshake with the instruction SRAM-like port (one request outstanding), holds one fetched instruction, and hands `{pc, inst}` to decode. It also consumes decode's branch bus and squashes or discards wrong-path fetches.

## Interface
- `RESET_PC`, default 32'h1c000000, address of the first fetch after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `br_bus`  in  34  `{br_target[31:0], br_taken, br_taken_cancel}` from decode. Only `br_target` and `br_taken_cancel` are used.
- `id_allowin`  in  1  decode can accept an instruction this cycle.
- `if_to_id_valid`  out  1  the `if_to_id_bus` content is valid.
- `if_to_id_bus`  out  64  `{fs_pc[31:0], fs_inst[31:0]}`.
- `inst_sram_req`  out  1  fetch request.
- `inst_sram_wr`  out  1  constant 0.
- `inst_sram_size`  out  2  constant 2'b10 (word).
- `inst_sram_addr`  out  32  fetch address, word aligned.
- `inst_sram_addr_ok`  in  1  request accepted this cycle (qualified by `req`).
- `inst_sram_data_ok`  in  1  read data valid this cycle.
- `inst_sram_rdata`  in  32  instruction word.

## Operation
Registers:
- `pf_pc`, the next address to request.
- `req_hold`, `req_addr`, `req_stale`: request presented but not yet accepted.
- `state`: `S_REQ` or `S_WAIT`.
- `wait_pc`: address of the outstanding request.
- `discard`: the outstanding request's data must be dropped.
- `fs_valid`, `fs_pc`, `fs_inst`: the output slot.

Request and response:
- `slot_free = !fs_valid || id_allowin`.
- In `S_REQ`: `inst_sram_req = req_hold || slot_free`.
- `inst_sram_addr = req_hold ? req_addr : pf_pc`. The address and req stay stable until `addr_ok`.
- In `S_REQ`, req high, no `addr_ok`: `req_hold <= 1` and `req_addr <= inst_sram_addr`.
- In `S_REQ`, `addr_ok`:
  - `req_hold <= 0`, `wait_pc <= inst_sram_addr`, `state <= S_WAIT`.
  - `pf_pc <= inst_sram_addr + 4`, unless a redirect applies this cycle.
  - `discard <= req_stale || br_taken_cancel`, then `req_stale <= 0`.
- `S_WAIT`: `inst_sram_req = 0`. On `data_ok`, `state <= S_REQ`:
  - If `discard`, drop the data and clear `discard`.
  - Else `fs_valid <= 1`, `fs_inst <= rdata`, `fs_pc <= wait_pc`.
- `data_ok` outside `S_WAIT` is ignored.
- The slot is always empty when data returns, because a request is issued only when the slot is free or freeing. No overflow is possible.

Hand-off to decode:
- `if_to_id_valid = fs_valid`.
- When `fs_valid && id_allowin`, `fs_valid <= 0`, unless a non-discarded `data_ok` refills the slot in the same cycle.

Redirect (`br_taken_cancel` = 1):
- `pf_pc <= br_target` (priority over +4).
- `fs_valid <= 0`; decode drops anything it accepts that cycle.
- `S_WAIT`, no `data_ok`: `discard <= 1`.
- `S_WAIT`, `data_ok` same cycle: that data is dropped, the slot is not written, no flag is set.
- `S_REQ`, req high, no `addr_ok`: `req_stale <= 1`. The request still completes at its old address and is discarded.
- `S_REQ`, req high, `addr_ok` same cycle: `discard <= 1`.
- `S_REQ`, req low: only the `pf_pc` and `fs_valid` updates apply.
- A second cancel cannot arrive before the discard resolves, because decode is empty. No queueing is required.

Reset (`resetn` = 0 at a clock edge):
- `pf_pc = RESET_PC`, `state = S_REQ`.
- `req_hold`, `req_stale`, `discard`, `fs_valid` = 0.
- `fs_pc`, `fs_inst`, `req_addr`, `wait_pc` = 0.
- Outputs: `if_to_id_valid = 0`, `if_to_id_bus = 0`.
- Reset asserted mid-transaction abandons it; the bench must not return `data_ok` for it after reset.

## Timing
- First request: the first cycle with `resetn` = 1, `addr = RESET_PC`.
- Latency `addr_ok` → `data_ok` ≥ 1 cycle. `if_to_id_valid` rises the cycle after `data_ok`.
- With zero-wait memory (`addr_ok` at req, `data_ok` next cycle), throughput is one instruction per 2 cycles.
- Redirect: the first request at `br_target` goes out in the cycle after cancel, or in the cycle after the stale response/acceptance resolves.
- `pf_pc` adds mod 2^32. Wrap-around from 32'hfffffffc to 0 is allowed.

## Test plan
- Reset, then memory with `addr_ok` = req and `data_ok` one cycle later, `id_allowin` = 1: addresses 1c000000, 1c000004, 1c000008 issued every 2 cycles. Decode sees the matching pc/inst pairs in order.
- Hold `id_allowin` = 0 with the slot full: `req` stays low, `if_to_id_bus` stays stable. Release: the next request goes out in the release cycle.
- Cancel with `br_target` = 1c000100 while in `S_WAIT`: the returning word is discarded, `if_to_id_valid` stays 0, and the next request address is 1c000100.
- `addr_ok` withheld 3 cycles, cancel in the 2nd cycle: `inst_sram_addr` stays at the old value until accepted. Its data is discarded, and the next request is to the target.
- Cancel in the same cycle as `data_ok` with `fs_valid` = 0: no instruction reaches decode, and the following request is to the target.
- Assert `resetn` = 0 mid-`S_WAIT` for one cycle: outputs return to their reset values, and the next request is to `RESET_PC`.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues word fetches over a req/addr_ok/data_ok port
// (one request outstanding), holds one fetched instruction for decode, and
// squashes or discards wrong-path fetches when decode redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [33:0] br_bus,
    input  logic        id_allowin,
    output logic        if_to_id_valid,
    output logic [63:0] if_to_id_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pf_pc_q, pf_pc_d;
    logic          req_hold_q, req_hold_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic          req_stale_q, req_stale_d;
    logic [AW-1:0] wait_pc_q, wait_pc_d;
    logic          discard_q, discard_d;
    logic          fs_valid_q, fs_valid_d;
    logic [AW-1:0] fs_pc_q, fs_pc_d;
    logic [DW-1:0] fs_inst_q, fs_inst_d;

    logic [AW-1:0] br_target;
    logic          br_cancel;
    logic          unused_br_taken;
    logic          slot_free;
    logic          req;
    logic [AW-1:0] addr;

    // Unpack the branch bus; br_taken is carried for decode's benefit only.
    assign br_target       = br_bus[33:2];
    assign unused_br_taken = br_bus[1];
    assign br_cancel       = br_bus[0];

    // A request may go out only if the slot is empty or draining this cycle;
    // a held request stays asserted until accepted.
    assign slot_free = !fs_valid_q || id_allowin;
    assign req       = (state_q == S_REQ) && (req_hold_q || slot_free);
    assign addr      = req_hold_q ? req_addr_q : pf_pc_q;

    assign inst_sram_req  = req;
    assign inst_sram_addr = addr;
    assign inst_sram_wr   = 1'b0;
    assign inst_sram_size = 2'b10;

    assign if_to_id_valid = fs_valid_q;
    assign if_to_id_bus   = {fs_pc_q, fs_inst_q};

    // Next-state: request handshake, response capture, hand-off and redirect.
    always_comb begin
        state_d     = state_q;
        pf_pc_d     = pf_pc_q;
        req_hold_d  = req_hold_q;
        req_addr_d  = req_addr_q;
        req_stale_d = req_stale_q;
        wait_pc_d   = wait_pc_q;
        discard_d   = discard_q;
        fs_valid_d  = fs_valid_q;
        fs_pc_d     = fs_pc_q;
        fs_inst_d   = fs_inst_q;

        // Decode takes the instruction; a refill below may override.
        if (fs_valid_q && id_allowin) begin
            fs_valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (req && !inst_sram_addr_ok) begin
                    req_hold_d = 1'b1;
                    req_addr_d = addr;
                    if (br_cancel) begin
                        req_stale_d = 1'b1;
                    end
                end else if (req && inst_sram_addr_ok) begin
                    req_hold_d  = 1'b0;
                    wait_pc_d   = addr;
                    state_d     = S_WAIT;
                    discard_d   = req_stale_q || br_cancel;
                    req_stale_d = 1'b0;
                    // A stale held request already has pf_pc pointing at the
                    // redirect target, so it must not be advanced past it.
                    if (!req_stale_q) begin
                        pf_pc_d = addr + AW'(4);
                    end
                end
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    state_d = S_REQ;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else if (!br_cancel) begin
                        fs_valid_d = 1'b1;
                        fs_inst_d  = inst_sram_rdata;
                        fs_pc_d    = wait_pc_q;
                    end
                end else if (br_cancel) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Redirect wins over sequential advance and flushes the slot.
        if (br_cancel) begin
            pf_pc_d    = br_target;
            fs_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_REQ;
            pf_pc_q     <= RESET_PC;
            req_hold_q  <= 1'b0;
            req_addr_q  <= '0;
            req_stale_q <= 1'b0;
            wait_pc_q   <= '0;
            discard_q   <= 1'b0;
            fs_valid_q  <= 1'b0;
            fs_pc_q     <= '0;
            fs_inst_q   <= '0;
        end else begin
            state_q     <= state_d;
            pf_pc_q     <= pf_pc_d;
            req_hold_q  <= req_hold_d;
            req_addr_q  <= req_addr_d;
            req_stale_q <= req_stale_d;
            wait_pc_q   <= wait_pc_d;
            discard_q   <= discard_d;
            fs_valid_q  <= fs_valid_d;
            fs_pc_q     <= fs_pc_d;
            fs_inst_q   <= fs_inst_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle handshake driving, address checks,
// and a scoreboard of instructions expected at decode.
module tb_if_stage;

    localparam logic [31:0] R  = 32'h1c000000;
    localparam logic [31:0] T  = 32'h1c000100;
    localparam logic [31:0] T2 = 32'h1c000200;
    localparam logic [31:0] T3 = 32'h1c000300;
    localparam logic [31:0] TW = 32'hfffffffc;

    logic        clk = 1'b0;
    logic        resetn;
    logic [33:0] br_bus;
    logic        id_allowin;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic [31:0] mem_addr;
    logic [63:0] sb_q[$];
    int          total = 0;
    int          bad   = 0;

    if_stage #(.RESET_PC(R)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .br_bus            (br_bus),
        .id_allowin        (id_allowin),
        .if_to_id_valid    (if_to_id_valid),
        .if_to_id_bus      (if_to_id_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5a5a0f0f;
    endfunction

    // Memory returns a word derived from the last accepted address.
    assign inst_sram_rdata = word_of(mem_addr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs are stable mid-cycle: latch accepted addresses and pop decode hand-offs.
    always @(negedge clk) begin
        if (resetn === 1'b1 && inst_sram_req === 1'b1 && inst_sram_addr_ok === 1'b1)
            mem_addr = inst_sram_addr;
        if (resetn === 1'b1 && if_to_id_valid === 1'b1 && id_allowin === 1'b1 && br_bus[0] === 1'b0) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'(if_to_id_valid), 64'd0);
            end else begin
                chk("sb_handoff", if_to_id_bus, sb_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic rstn, input logic aok, input logic dok,
                       input logic allow, input logic canc, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        resetn            = rstn;
        inst_sram_addr_ok = aok;
        inst_sram_data_ok = dok;
        id_allowin        = allow;
        br_bus            = {tgt, canc, canc};
        #1;
    endtask

    task automatic chk_req(input string tag, input logic exp_req, input logic [31:0] exp_addr);
        chk({tag, "_req"}, 64'(inst_sram_req), 64'(exp_req));
        if (exp_req) chk({tag, "_addr"}, 64'(inst_sram_addr), 64'(exp_addr));
    endtask

    task automatic push(input logic [31:0] pc);
        sb_q.push_back({pc, word_of(pc)});
    endtask

    initial begin
        resetn = 1'b0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
        id_allowin = 1'b1; br_bus = '0; mem_addr = '0;

        // Reset
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("rst_valid", 64'(if_to_id_valid), 64'd0);
        chk("rst_bus", if_to_id_bus, 64'd0);
        chk("const_wr_size", {61'd0, inst_sram_wr, inst_sram_size}, 64'd2);

        // Zero-wait streaming
        cyc(1, 1, 0, 1, 0, 0); chk_req("c1", 1, R);
        cyc(1, 0, 1, 1, 0, 0); chk_req("c2", 0, 0); push(R);
        cyc(1, 1, 0, 1, 0, 0); chk_req("c3", 1, R + 4); chk("c3_valid", 64'(if_to_id_valid), 64'd1);
        cyc(1, 0, 1, 1, 0, 0); chk_req("c4", 0, 0); push(R + 4);
        cyc(1, 1, 0, 1, 0, 0); chk_req("c5", 1, R + 8);
        cyc(1, 0, 1, 0, 0, 0); push(R + 8);

        // Decode stall with slot full
        cyc(1, 1, 0, 0, 0, 0); chk_req("stall1", 0, 0);
        chk("stall1_bus", if_to_id_bus, {R + 32'd8, word_of(R + 8)});
        cyc(1, 1, 0, 0, 0, 0); chk_req("stall2", 0, 0);
        chk("stall2_bus", if_to_id_bus, {R + 32'd8, word_of(R + 8)});
        cyc(1, 1, 0, 1, 0, 0); chk_req("release", 1, R + 12);

        // Cancel in S_WAIT
        cyc(1, 0, 0, 1, 1, T); chk_req("wcan", 0, 0);
        cyc(1, 0, 1, 1, 0, 0); chk_req("wcan_drop", 0, 0);
        cyc(1, 1, 0, 1, 0, 0); chk_req("wcan_tgt", 1, T);
        chk("wcan_valid", 64'(if_to_id_valid), 64'd0);
        cyc(1, 0, 1, 1, 0, 0); push(T);

        // addr_ok withheld three cycles, cancel in the second
        cyc(1, 0, 0, 1, 0, 0);  chk_req("hold1", 1, T + 4);
        cyc(1, 0, 0, 1, 1, T2); chk_req("hold2", 1, T + 4);
        cyc(1, 0, 0, 1, 0, 0);  chk_req("hold3", 1, T + 4);
        cyc(1, 1, 0, 1, 0, 0);  chk_req("hold_acc", 1, T + 4);
        cyc(1, 0, 1, 1, 0, 0);  chk_req("hold_drop", 0, 0);
        cyc(1, 1, 0, 1, 0, 0);  chk_req("hold_tgt", 1, T2);
        chk("hold_valid", 64'(if_to_id_valid), 64'd0);

        // Cancel together with data_ok, slot empty
        cyc(1, 0, 1, 1, 1, T3); chk("dcan_valid0", 64'(if_to_id_valid), 64'd0);
        cyc(1, 1, 0, 1, 0, 0);  chk_req("dcan_tgt", 1, T3);
        chk("dcan_valid1", 64'(if_to_id_valid), 64'd0);
        cyc(1, 0, 1, 1, 0, 0);  push(T3);
        cyc(1, 1, 0, 1, 0, 0);  chk_req("pre_rst", 1, T3 + 4);

        // Reset mid-S_WAIT
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, 0);  chk_req("post_rst", 1, R);
        chk("post_rst_valid", 64'(if_to_id_valid), 64'd0);
        chk("post_rst_bus", if_to_id_bus, 64'd0);
        cyc(1, 0, 1, 1, 0, 0);  push(R);
        cyc(1, 1, 0, 1, 0, 0);  chk_req("post_rst2", 1, R + 4);

        // Redirect to the top of the address space and wrap to 0
        cyc(1, 0, 1, 1, 1, TW);
        cyc(1, 1, 0, 1, 0, 0);  chk_req("wrap_top", 1, TW);
        cyc(1, 0, 1, 1, 0, 0);  push(TW);
        cyc(1, 1, 0, 1, 0, 0);  chk_req("wrap_zero", 1, 32'd0);
        cyc(1, 0, 1, 1, 0, 0);  push(32'd0);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
